// File: rtl/rc_ctrl_pkg.sv
// rtl/rc_ctrl_pkg.sv - shared opcodes, register selects and state encoding for the RC sequencer
package rc_ctrl_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_MV   = 2'b11;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_Z   = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_S1   = 2'b01,
    ST_S2   = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  typedef struct packed {
    logic ra_in;
    logic rb_in;
    logic rz_in;
    logic ra_out;
    logic rb_out;
    logic rz_out;
  } strobes_t;

endpackage

// File: rtl/rc_control_sequencer_if.sv
// rtl/rc_control_sequencer_if.sv - decoded-instruction handshake between decode and sequencer
interface rc_control_sequencer_if #(
  parameter int IMM_W = 8,
  parameter int SEL_W = 2
) ();

  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       opcode;
  logic [SEL_W-1:0] rd;
  logic [SEL_W-1:0] rs;
  logic [IMM_W-1:0] imm;

  modport master (
    output instr_valid,
    output opcode,
    output rd,
    output rs,
    output imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  rd,
    input  rs,
    input  imm,
    output instr_ready
  );

endinterface

// File: rtl/rc_strobe_decode.sv
// rtl/rc_strobe_decode.sv - combinational map from sequencer step to datapath strobes/immediates
module rc_strobe_decode
  import rc_ctrl_pkg::*;
#(
  parameter int IMM_W = 8,
  parameter int SEL_W = 2
) (
  input  state_t           state,
  input  logic [1:0]       opcode,
  input  logic [SEL_W-1:0] rs,
  input  logic [SEL_W-1:0] rd,
  input  logic [IMM_W-1:0] imm,
  output strobes_t         strobes,
  output logic [IMM_W-1:0] add_imm,
  output logic [IMM_W-1:0] rega_imm
);

  // Each step drives one source onto the bus and loads one register; unused immediates stay 0
  always_comb begin
    strobes  = '0;
    add_imm  = '0;
    rega_imm = '0;
    case (state)
      ST_S1: begin
        if (opcode == OP_LDI) begin
          rega_imm      = imm;
          strobes.ra_in = 1'b1;
        end else if (opcode == OP_ADDI || opcode == OP_MV) begin
          // Source goes through the adder into Z; MV is an add of zero
          strobes.ra_out = (rs == SEL_W'(SEL_A));
          strobes.rb_out = (rs == SEL_W'(SEL_B));
          strobes.rz_in  = 1'b1;
          add_imm        = (opcode == OP_ADDI) ? imm : '0;
        end
      end
      ST_S2: begin
        if (opcode == OP_ADDI || opcode == OP_MV) begin
          strobes.rz_out = 1'b1;
          strobes.ra_in  = (rd == SEL_W'(SEL_A));
          strobes.rb_in  = (rd == SEL_W'(SEL_B));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc_control_sequencer.sv
// rtl/rc_control_sequencer.sv - hardwired control sequencer driving the RC datapath strobes
module rc_control_sequencer
  import rc_ctrl_pkg::*;
#(
  parameter int IMM_W = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  rc_control_sequencer_if.slave instr,
  output logic                  RAin,
  output logic                  RBin,
  output logic                  RZin,
  output logic                  RAout,
  output logic                  RBout,
  output logic                  RZout,
  output logic [IMM_W-1:0]      AddImmediate,
  output logic [IMM_W-1:0]      RegisterAImmediate,
  output logic                  done,
  output logic                  illegal
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic [SEL_W-1:0] rd_q;
  logic [SEL_W-1:0] rs_q;
  logic [IMM_W-1:0] imm_q;
  logic             illegal_q;
  logic             accept;
  logic             legal;
  strobes_t         strobes;
  logic [IMM_W-1:0] add_imm;
  logic [IMM_W-1:0] rega_imm;

  // Only the idle state takes a new instruction, so accepts can never be back to back
  assign accept = instr.instr_valid && (state_q == ST_IDLE);

  // Legality of the presented instruction: Z and the reserved select are never valid operands
  always_comb begin
    legal = 1'b0;
    case (instr.opcode)
      OP_NOP:  legal = 1'b1;
      OP_LDI:  legal = (instr.rd == SEL_W'(SEL_A));
      OP_ADDI,
      OP_MV:   legal = ((instr.rd == SEL_W'(SEL_A)) || (instr.rd == SEL_W'(SEL_B))) &&
                       ((instr.rs == SEL_W'(SEL_A)) || (instr.rs == SEL_W'(SEL_B)));
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction capture register, loaded only on the accepting edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q      <= OP_NOP;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q      <= instr.opcode;
      rd_q      <= instr.rd;
      rs_q      <= instr.rs;
      imm_q     <= instr.imm;
      illegal_q <= !legal;
    end
  end

  // Next-state: NOP and rejected instructions retire immediately, LDI takes one step, ADDI/MV two
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (instr.opcode == OP_NOP || !legal) ? ST_FIN : ST_S1;
        end
      end
      ST_S1:   state_d = (op_q == OP_LDI) ? ST_FIN : ST_S2;
      ST_S2:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  rc_strobe_decode #(
    .IMM_W (IMM_W),
    .SEL_W (SEL_W)
  ) u_strobe_decode (
    .state    (state_q),
    .opcode   (op_q),
    .rs       (rs_q),
    .rd       (rd_q),
    .imm      (imm_q),
    .strobes  (strobes),
    .add_imm  (add_imm),
    .rega_imm (rega_imm)
  );

  // Outputs come only from registered state, never straight from the instruction inputs
  always_comb begin
    instr.instr_ready  = (state_q == ST_IDLE);
    done               = (state_q == ST_FIN);
    illegal            = (state_q == ST_FIN) && illegal_q;
    RAin               = strobes.ra_in;
    RBin               = strobes.rb_in;
    RZin               = strobes.rz_in;
    RAout              = strobes.ra_out;
    RBout              = strobes.rb_out;
    RZout              = strobes.rz_out;
    AddImmediate       = add_imm;
    RegisterAImmediate = rega_imm;
  end

endmodule
